// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the memory stage and mem_access_unit.
// master drives req_*, slave (the unit) drives req_ready and rsp_*.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, misaligned halves/words are
// split into byte accesses so the RAM only sees naturally aligned transfers.
// Ports: clk, rst (async, active high); bus (slave: req_* in, rsp_* out);
// ram_word_addr/ram_data_in/ram_write_ctrl/ram_read_ctrl out; ram_out in.
module mem_access_unit #(
    parameter int unsigned MEM_SIZE = 32'h0040_0000
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus,
    output logic [31:0]        ram_word_addr,
    output logic [31:0]        ram_data_in,
    output logic [1:0]         ram_write_ctrl,
    output logic [2:0]         ram_read_ctrl,
    input  logic [31:0]        ram_out
);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  idx_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_din_q;
    logic [1:0]  ram_wc_q;
    logic [2:0]  ram_rc_q;

    function automatic logic [2:0] rd_ctrl(input logic [2:0] f3);
        unique case (f3)
            3'b000:  return 3'b101;
            3'b001:  return 3'b011;
            3'b010:  return 3'b001;
            3'b100:  return 3'b100;
            3'b101:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] wr_ctrl(input logic [1:0] sz);
        unique case (sz)
            2'b00:   return 2'b10;
            2'b01:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // Request classification, evaluated on the incoming request in IDLE.
    logic [2:0]  acc_size;
    logic        f3_illegal;
    logic        out_of_range;
    logic        is_aligned;
    logic [32:0] last_byte;

    always_comb begin
        unique case (bus.req_funct3[1:0])
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
        if (bus.req_we)
            f3_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        else
            f3_illegal = (bus.req_funct3[1:0] == 2'b11)
                      || (bus.req_funct3[2:1] == 2'b11);
        // 33-bit sum so a request at the top of the address space cannot wrap.
        last_byte    = {1'b0, bus.req_addr} + {30'd0, acc_size} - 33'd1;
        out_of_range = last_byte >= MEM_LIMIT;
        unique case (bus.req_funct3[1:0])
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~bus.req_addr[0];
            default: is_aligned = (bus.req_addr[1:0] == 2'b00);
        endcase
    end

    // Split loads: byte i of the current cycle merged into the partial result.
    logic [1:0]  idx_nx;
    logic        split_last;
    logic [31:0] merged;
    logic [31:0] split_rdata;

    always_comb begin
        idx_nx     = idx_q + 2'd1;
        split_last = (idx_q == (f3_q[0] ? 2'd1 : 2'd3));
        merged     = result_q;
        merged[{idx_q, 3'b000} +: 8] = ram_out[7:0];
        unique case (f3_q)
            3'b001:  split_rdata = {{16{merged[15]}}, merged[15:0]};
            3'b101:  split_rdata = {16'd0, merged[15:0]};
            default: split_rdata = merged;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            idx_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_wc_q    <= '0;
            ram_rc_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        we_q     <= bus.req_we;
                        f3_q     <= bus.req_funct3;
                        idx_q    <= '0;
                        result_q <= '0;
                        if (f3_illegal || out_of_range) begin
                            state_q     <= RESP;
                            rsp_rdata_q <= '0;
                            rsp_fault_q <= 1'b1;
                        end else begin
                            ram_addr_q <= bus.req_addr;
                            if (is_aligned) begin
                                state_q   <= ACCESS;
                                ram_din_q <= bus.req_we ? bus.req_wdata : '0;
                                ram_wc_q  <= bus.req_we ?
                                             wr_ctrl(bus.req_funct3[1:0]) : 2'b00;
                                ram_rc_q  <= bus.req_we ?
                                             3'b000 : rd_ctrl(bus.req_funct3);
                            end else begin
                                state_q   <= SPLIT;
                                ram_din_q <= bus.req_we ?
                                             {24'd0, bus.req_wdata[7:0]} : '0;
                                ram_wc_q  <= bus.req_we ? 2'b10 : 2'b00;
                                ram_rc_q  <= bus.req_we ? 3'b000 : 3'b100;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    rsp_rdata_q <= we_q ? '0 : ram_out;
                    rsp_fault_q <= 1'b0;
                    ram_addr_q  <= '0;
                    ram_din_q   <= '0;
                    ram_wc_q    <= '0;
                    ram_rc_q    <= '0;
                end
                SPLIT: begin
                    result_q <= merged;
                    if (split_last) begin
                        state_q     <= RESP;
                        rsp_rdata_q <= we_q ? '0 : split_rdata;
                        rsp_fault_q <= 1'b0;
                        ram_addr_q  <= '0;
                        ram_din_q   <= '0;
                        ram_wc_q    <= '0;
                        ram_rc_q    <= '0;
                    end else begin
                        idx_q      <= idx_nx;
                        ram_addr_q <= addr_q + {30'd0, idx_nx};
                        ram_din_q  <= we_q ?
                                      {24'd0, wdata_q[{idx_nx, 3'b000} +: 8]} : '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_fault  = rsp_fault_q;
    assign ram_word_addr  = ram_addr_q;
    assign ram_data_in    = ram_din_q;
    assign ram_write_ctrl = ram_wc_q;
    assign ram_read_ctrl  = ram_rc_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the core's memory stage and the byte-addressed data RAM port. Accepts one RISC-V load/store request at a time through a valid/ready handshake and drives the RAM's address, data, write-control and read-control lines. Misaligned halfword and word accesses are split into sequential byte accesses, so the RAM only ever sees naturally aligned transfers. Returns load data or a fault through a single-cycle response strobe.

## Interface
- MEM_SIZE, 4<<20: RAM size in bytes, used for the bounds check.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe; no back-pressure.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults.
- rsp_fault  out  1  out-of-range or illegal funct3; qualified by rsp_valid.
- ram_word_addr  out  32  byte address to RAM.
- ram_data_in  out  32  write data to RAM.
- ram_write_ctrl  out  2  write control: 11 word, 01 half, 10 byte, 00 none.
- ram_read_ctrl  out  3  read control: 001 LW, 010 LHU, 011 LH, 100 LBU, 101 LB, 000 none.
- ram_out  in  32  RAM read data; combinational from the current address and read control.

## Operation
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. On req_valid the request is captured (addr, we, funct3, wdata), then classified:
  - Illegal funct3 (load 011/110/111; store 1xx/011) -> RESP with fault.
  - Out of range (addr+size-1 >= MEM_SIZE, computed in 33 bits) -> RESP with fault.
  - Aligned (byte any; half addr[0]=0; word addr[1:0]=00) -> ACCESS.
  - Otherwise -> SPLIT with byte count N=2 (half) or N=4 (word), index i=0.
- ACCESS (1 cycle):
  - ram_word_addr=addr.
  - Load: ram_read_ctrl per funct3 mapping, ram_write_ctrl=00; ram_out captured into the result register at cycle end.
  - Store: ram_write_ctrl per size, ram_data_in=wdata, ram_read_ctrl=000.
  - Next state RESP.
- SPLIT (N cycles, i=0..N-1):
  - ram_word_addr=addr+i (32-bit wrap, unreachable after the bounds check).
  - Store: ram_write_ctrl=10, ram_data_in={24'd0, wdata[8i+7:8i]}.
  - Load: ram_read_ctrl=100; ram_out[7:0] captured into result byte i.
  - After i=N-1 -> RESP.
- RESP (1 cycle):
  - rsp_valid=1.
  - rsp_rdata for split loads is extended per funct3: LH sign-extends bit 15, LHU zero-extends, LW passes through.
  - rsp_rdata for aligned loads is ram_out as captured; stores and faults give 0.
  - Next state IDLE.
- The ram_* outputs are driven only from registered state; there is no combinational path from req_* to ram_*.
- Outside ACCESS and SPLIT: ram_write_ctrl=00, ram_read_ctrl=000, ram_word_addr=0, ram_data_in=0.
- rsp_rdata and rsp_fault hold their values after RESP until the next response.
- Reset in any state forces IDLE and reset values immediately. An in-progress split store is abandoned with its earlier bytes left written; no further RAM write occurs.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, all ram_* outputs 0.
- Acceptance cycle is cycle 0 (posedge with req_valid & req_ready).
- Aligned access: RAM active in cycle 1; store commits at the end of cycle 1; rsp_valid in cycle 2.
- Split access: RAM active in cycles 1..N; rsp_valid in cycle N+1.
- Fault: no RAM activity; rsp_valid in cycle 1.
- req_ready=0 from cycle 1 through RESP inclusive, so back-to-back requests are accepted no sooner than the cycle after RESP.
- ram_write_ctrl is non-zero for exactly 1 cycle per aligned store and N cycles per split store.

## Test plan
- Reset: assert rst mid-cycle -> all outputs at reset values immediately; req_ready=1 after release.
- SW 0xDEADBEEF @0x100, then LW @0x100:
  - Store: ram_write_ctrl=11 for exactly one cycle.
  - Load: rsp_rdata=0xDEADBEEF, rsp_valid in cycle 2, rsp_fault=0.
- Follow-up loads on the same data:
  - LB @0x103 -> 0xFFFFFFDE.
  - LBU @0x103 -> 0x000000DE.
  - LH @0x102 -> 0xFFFFDEAD.
  - LHU @0x100 -> 0x0000BEEF.
- Misaligned SW 0x11223344 @0x101:
  - Byte writes 44, 33, 22, 11 to 0x101..0x104 in cycles 1..4, rsp_valid in cycle 5.
  - LW @0x101 -> 0x11223344 in cycle 5.
  - LH @0x103 -> 0x00001122.
- Faults, each giving rsp_fault=1, rsp_rdata=0, rsp_valid in cycle 1, ram_* all 0 throughout:
  - LW @MEM_SIZE-2.
  - Load funct3=011 @0x0.
  - Store funct3=100.
- Reset during a misaligned SW @0x201 after 2 byte cycles -> ram_write_ctrl=00 immediately; bytes 0x203/0x204 unchanged; next LBU @0x201 returns the stored low byte.
